// File: rtl/sort_engine.sv
// Streaming frame sorter: captures up to DEPTH words, sorts them with an
// odd-even transposition network (one pass per cycle), then streams them out.
module sort_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  input  logic              descend,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic [CNT_W-1:0]  frame_len
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SORT, S_OUT} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  arr_q [DEPTH];
  logic [DATA_W-1:0]  arr_d [DEPTH];
  logic [DATA_W-1:0]  sorted_w [DEPTH];
  logic [DEPTH-2:0]   swap_w;

  logic in_hs, in_end, out_hs, out_end, last_pass;

  assign in_hs     = (state_q == S_READ) && ss_tvalid;
  assign in_end    = in_hs && (ss_tlast || (count_q == CNT_W'(DEPTH - 1)));
  assign out_hs    = (state_q == S_OUT) && sm_tready;
  assign out_end   = out_hs && (idx_q == count_q - CNT_W'(1));
  assign last_pass = (pass_q == CNT_W'(DEPTH - 1));

  // Even passes compare pairs starting at even indices, odd passes at odd ones.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH - 1; gi++) begin : g_pair
      localparam logic ODD = ((gi % 2) == 1);
      assign swap_w[gi] = (pass_q[0] == ODD) &&
                          (mode_q ? (arr_q[gi] < arr_q[gi+1])
                                  : (arr_q[gi] > arr_q[gi+1]));
    end

    // Active pairs are disjoint, so each cell takes at most one neighbour.
    for (gi = 0; gi < DEPTH; gi++) begin : g_cell
      if (gi == 0) begin : g_first
        assign sorted_w[gi] = swap_w[0] ? arr_q[1] : arr_q[0];
      end else if (gi == DEPTH - 1) begin : g_last
        assign sorted_w[gi] = swap_w[gi-1] ? arr_q[gi-1] : arr_q[gi];
      end else begin : g_mid
        assign sorted_w[gi] = swap_w[gi-1] ? arr_q[gi-1] :
                              (swap_w[gi] ? arr_q[gi+1] : arr_q[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      count_q <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= arr_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ap_start)  state_d = S_READ;
      S_READ: if (in_end)    state_d = S_SORT;
      S_SORT: if (last_pass) state_d = S_OUT;
      S_OUT:  if (out_end)   state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    for (int i = 0; i < DEPTH; i++) arr_d[i] = arr_q[i];
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          mode_d  = descend;
          count_d = '0;
          pass_d  = '0;
          // Pre-fill with a pad that sorts to the tail; READ overwrites the head.
          for (int i = 0; i < DEPTH; i++) arr_d[i] = descend ? '0 : '1;
        end
      end
      S_READ: begin
        if (in_hs) begin
          for (int i = 0; i < DEPTH; i++)
            if (count_q == CNT_W'(i)) arr_d[i] = ss_tdata;
          count_d = count_q + CNT_W'(1);
          pass_d  = '0;
        end
      end
      S_SORT: begin
        for (int i = 0; i < DEPTH; i++) arr_d[i] = sorted_w[i];
        pass_d = pass_q + CNT_W'(1);
        idx_d  = '0;
      end
      S_OUT: begin
        if (out_end)     done_d = 1'b1;
        else if (out_hs) idx_d  = idx_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ap_idle   = (state_q == S_IDLE);
    ap_done   = done_q;
    ss_tready = (state_q == S_READ);
    sm_tvalid = (state_q == S_OUT);
    sm_tlast  = (state_q == S_OUT) && (idx_q == count_q - CNT_W'(1));
    frame_len = count_q;
    sm_tdata  = '0;
    if (state_q == S_OUT) begin
      for (int i = 0; i < DEPTH; i++)
        if (idx_q == CNT_W'(i)) sm_tdata = arr_q[i];
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: frames in both orders, short frames,
// backpressure, overlong input and reset during SORT/OUT.
module tb_sort_engine;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ap_start = 1'b0;
  logic              descend = 1'b0;
  logic              ap_idle, ap_done;
  logic              ss_tvalid = 1'b0;
  logic [DATA_W-1:0] ss_tdata = '0;
  logic              ss_tlast = 1'b0;
  logic              ss_tready;
  logic              sm_tvalid;
  logic [DATA_W-1:0] sm_tdata;
  logic              sm_tlast;
  logic              sm_tready = 1'b0;
  logic [CNT_W-1:0]  frame_len;

  sort_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .descend(descend),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int r_cyc    = 0;
  int unsigned vin[$];
  int unsigned vexp[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_idle"},  ap_idle,   1);
    check({tag, "_done"},  ap_done,   0);
    check({tag, "_sready"}, ss_tready, 0);
    check({tag, "_mvalid"}, sm_tvalid, 0);
    check({tag, "_mlast"}, sm_tlast,  0);
    check({tag, "_mdata"}, sm_tdata,  0);
    check({tag, "_flen"},  frame_len, 0);
  endtask

  task automatic start(input logic d);
    @(negedge clk);
    ap_start = 1'b1;
    descend  = d;
    @(negedge clk);
    ap_start = 1'b0;
    check("start_sready", ss_tready, 1);
    check("start_flen", frame_len, 0);
  endtask

  // Sends vin; tlast on the final word when use_last is set.
  task automatic send(input bit use_last);
    int guard;
    for (int i = 0; i < vin.size(); i++) begin
      ss_tvalid = 1'b1;
      ss_tdata  = vin[i];
      ss_tlast  = use_last && (i == vin.size() - 1);
      guard = 0;
      while (!ss_tready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("send_timeout", 1, 0);
      r_cyc = cyc;
      @(negedge clk);
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  // Collects vexp; bp selects the 1,0,0,1 ready pattern; chain issues ap_start on ap_done.
  task automatic receive(input bit bp, input bit chain, input logic chain_desc);
    int guard = 0;
    int k = 0;
    int cnt = 0;
    while (!sm_tvalid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("latency", cyc - r_cyc, DEPTH + 1);
    while (k < vexp.size() && cnt < 400) begin
      sm_tready = bp ? ((cnt % 4 == 0) || (cnt % 4 == 3)) : 1'b1;
      check("out_valid", sm_tvalid, 1);
      check("out_data", sm_tdata, vexp[k]);
      check("out_last", sm_tlast, (k == vexp.size() - 1));
      $display("beat %0d data %0h last %0b ready %0b", k, sm_tdata, sm_tlast, sm_tready);
      if (sm_tready) k++;
      @(negedge clk);
      cnt++;
    end
    sm_tready = 1'b0;
    check("done_pulse", ap_done, 1);
    check("done_idle", ap_idle, 1);
    check("done_mvalid", sm_tvalid, 0);
    if (chain) begin
      ap_start = 1'b1;
      descend  = chain_desc;
    end
    @(negedge clk);
    ap_start = 1'b0;
    check("done_single", ap_done, 0);
    check("after_mvalid", sm_tvalid, 0);
    if (chain) check("chain_sready", ss_tready, 1);
  endtask

  task automatic quiet_done(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(tag, ap_done, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Full ascending frame.
    start(0);
    vin = '{9, 3, 7, 1, 0, 8, 2, 6, 5, 4};
    send(1);
    check("full_flen", frame_len, 10);
    vexp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    receive(0, 0, 0);

    // Descending with duplicates and extreme values.
    start(1);
    vin = '{5, 5, 32'hFFFFFFFF, 0, 3, 3, 3, 1, 2, 0};
    send(1);
    check("dup_flen", frame_len, 10);
    vexp = '{32'hFFFFFFFF, 5, 5, 3, 3, 3, 2, 1, 0, 0};
    receive(0, 0, 0);

    // Short frames in both orders: pads must never appear.
    start(0);
    vin = '{40, 10, 30, 20};
    send(1);
    check("short_asc_flen", frame_len, 4);
    vexp = '{10, 20, 30, 40};
    receive(0, 0, 0);
    check("short_flen_hold", frame_len, 4);

    start(1);
    send(1);
    check("short_desc_flen", frame_len, 4);
    vexp = '{40, 30, 20, 10};
    receive(0, 0, 0);

    // Backpressure, then back-to-back start on ap_done.
    start(0);
    vin = '{70, 20, 90, 10, 60, 30, 80, 0, 50, 40};
    send(1);
    vexp = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90};
    receive(1, 1, 1);
    vin = '{1, 2};
    send(1);
    check("b2b_flen", frame_len, 2);
    vexp = '{2, 1};
    receive(0, 0, 0);

    // Overlong input: only DEPTH beats taken, the rest wait for the next frame.
    start(0);
    vin = '{100, 99, 98, 97, 96, 95, 94, 93, 92, 91};
    send(0);
    ss_tvalid = 1'b1;
    ss_tdata  = 7;
    check("over_sready0", ss_tready, 0);
    check("over_flen", frame_len, 10);
    @(negedge clk);
    check("over_sready1", ss_tready, 0);
    vexp = '{91, 92, 93, 94, 95, 96, 97, 98, 99, 100};
    receive(0, 0, 0);
    check("over_pending_sready", ss_tready, 0);
    start(0);
    vin = '{7, 500, 50};
    send(1);
    check("over_next_flen", frame_len, 3);
    vexp = '{7, 50, 500};
    receive(0, 0, 0);

    // Reset during SORT.
    start(0);
    vin = '{3, 1, 2};
    send(1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_sort");
    rst = 1'b0;
    quiet_done("rst_sort_nodone");
    start(1);
    vin = '{1, 9, 5};
    send(1);
    vexp = '{9, 5, 1};
    receive(0, 0, 0);

    // Reset during OUT.
    start(0);
    vin = '{8, 6, 7, 5};
    send(1);
    for (int g = 0; g < 100 && !sm_tvalid; g++) @(negedge clk);
    check("rst_out_first", sm_tdata, 5);
    sm_tready = 1'b1;
    @(negedge clk);
    sm_tready = 1'b0;
    check("rst_out_second", sm_tdata, 6);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_out");
    rst = 1'b0;
    quiet_done("rst_out_nodone");
    start(0);
    vin = '{2, 1};
    send(1);
    vexp = '{1, 2};
    receive(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised streaming sorter replacing the fixed 10×32-bit sorter in the user-project ASIC datapath. Accepts one frame of up to DEPTH unsigned words on an AXI-Stream slave, sorts it in place with an odd-even transposition network (ascending or descending, selected per frame), and returns the sorted frame on an AXI-Stream master with full backpressure. It sits between the DMA/FIFO input stream and the output FIFO, controlled by the ap_start/ap_done/ap_idle block-control signals.

## Interface
- DATA_W, 32, word width in bits (≥1); comparisons are unsigned.
- DEPTH, 10, maximum words per frame (≥2); CNT_W = $clog2(DEPTH+1) is a localparam.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ap_start  in  1  begin a frame; sampled only in IDLE.
- descend  in  1  sort order, sampled with ap_start: 0 ascending, 1 descending.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  one-cycle pulse when the frame completes.
- ss_tvalid  in  1  input beat valid.
- ss_tdata  in  DATA_W  input word.
- ss_tlast  in  1  final word of the input frame.
- ss_tready  out  1  input ready.
- sm_tvalid  out  1  output beat valid.
- sm_tdata  out  DATA_W  sorted output word.
- sm_tlast  out  1  final word of the output frame.
- sm_tready  in  1  downstream ready.
- frame_len  out  CNT_W  number of words captured in the current/last frame.

## Operation
- States: IDLE → READ → SORT → OUT → IDLE.
- IDLE: ap_idle=1. When ap_start=1: latch descend into an internal mode bit, clear the word count, and go to READ. ap_start outside IDLE is ignored.
- READ: ss_tready=1. On each handshake (ss_tvalid&ss_tready), write ss_tdata to arr[count] and increment count. The frame ends on a beat with ss_tlast=1, or on the DEPTH-th beat regardless of ss_tlast; the state then becomes SORT. Unused slots arr[count..DEPTH-1] are loaded with a pad value that sorts to the tail: all-ones when ascending, zero when descending.
- SORT: runs exactly DEPTH passes, one per cycle, alternating even pairs (0-1, 2-3, …) and odd pairs (1-2, 3-4, …), starting with even. A pair is swapped when it is out of order for the latched mode. Equal values are never swapped. The state then becomes OUT.
- OUT: sm_tvalid=1 and sm_tdata=arr[idx], starting at idx=0. idx advances on each sm_tvalid&sm_tready. sm_tlast=1 when idx==count-1. Only count words are emitted; pad slots are never output. After the last handshake the state becomes IDLE and ap_done pulses.
- frame_len is updated during READ and holds its value until the next ap_start.

## Timing
- Reset values: the state is IDLE. ap_idle=1; ap_done, ss_tready, sm_tvalid and sm_tlast are 0; sm_tdata=0; frame_len=0. All arr entries and counters are cleared.
- ss_tready and sm_tvalid are registered, or are direct decodes of the registered state. There is no combinational path from ss_tvalid to ss_tready, or from sm_tready to sm_tvalid.
- ap_start is high in cycle t → ss_tready is high from t+1.
- Last input beat accepted in cycle r → SORT occupies r+1 … r+DEPTH. sm_tvalid rises at r+DEPTH+1 with the first sorted word.
- With sm_tready held at 1, one word is emitted per cycle. The final handshake occurs in cycle o; in cycle o+1 ap_done=1, ap_idle=1 and sm_tvalid=0.
- Backpressure: while sm_tvalid=1 and sm_tready=0, sm_tdata and sm_tlast hold stable.
- An idle input (ss_tvalid=0) in READ simply waits; there is no timeout.
- rst asserted in any state returns the block to its reset values on the next edge. A partial frame is discarded and no ap_done is issued.
- A back-to-back ap_start in the cycle of ap_done is accepted, because the block is already in IDLE.

## Test plan
- Full frame, ascending, DEPTH=10: input 9,3,7,1,0,8,2,6,5,4, tlast on the 10th beat → output 0..9; sm_tlast only on 9; ap_done one cycle later; first sm_tvalid exactly 11 cycles after the last input beat.
- Descending with duplicates: 5,5,0xFFFFFFFF,0,3,3,3,1,2,0 → 0xFFFFFFFF,5,5,3,3,3,2,1,0,0; frame_len=10.
- Short frame: 4 words 40,10,30,20 with tlast on the 4th, ascending → exactly 4 beats 10,20,30,40; sm_tlast on 40; frame_len=4; no pad words emitted. Repeat descending: 40,30,20,10.
- Backpressure: toggle sm_tready 1,0,0,1,… during OUT → each word held stable while stalled; full sequence intact; no duplicated or dropped beats.
- Overlong input: 12 beats with no tlast → the first 10 are accepted and ss_tready drops after the 10th; the remaining beats stay pending, and the next frame accepts them after ap_start.
- Reset mid-SORT and mid-OUT → all outputs return to their reset values next cycle; no ap_done; a following fresh frame sorts correctly.
